// File: rtl/float_pack.sv
// Shared format constants, float struct and FSM state encoding for the
// sequential floating-point add/sub unit.
package float_pack;

  localparam int Ne   = 8;
  localparam int Nm   = 23;
  localparam int BIAS = (1 << (Ne - 1)) - 1;

  typedef struct packed {
    logic          sign;
    logic [Ne-1:0] exp;
    logic [Nm-1:0] man;
  } float_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/find_first_one.sv
// Leading-zero counter: number of zero bits above the most significant one.
// An all-zero input reports W.
module find_first_one #(
  parameter int W  = 28,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] lz_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    lz_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) lz_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/float_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor: one operation in flight,
// stepping IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Significands carry hidden one + mantissa + guard/round/sticky (Nm+4 bits);
// the adder result has one extra carry bit on top (Nm+5 bits).
module float_addsub_seq #(
  parameter int Ne = float_pack::Ne,
  parameter int Nm = float_pack::Nm
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [Ne+Nm:0] a_i,
  input  logic [Ne+Nm:0] b_i,
  input  logic           op_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [Ne+Nm:0] result_o,
  output logic           ovf_o,
  output logic           unf_o
);

  localparam int FW = 1 + Ne + Nm;
  localparam int SW = Nm + 4;
  localparam int AW = Nm + 5;
  localparam int EW = Ne + 2;
  localparam int CW = $clog2(AW + 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << Ne) - 2);
  localparam logic signed [EW-1:0] EONE = EW'(1);

  float_pack::state_t state_q;

  logic                 in_ready_q, out_valid_q, ovf_q, unf_q;
  logic [FW-1:0]        result_q, a_q, b_q, byp_res_q;
  logic                 op_q, sgn_q, sub_q, byp_q;
  logic signed [EW-1:0] exp_q;
  logic [SW-1:0]        sx_q, sy_q, norm_q;
  logic [AW-1:0]        sum_q;

  // ALIGN-stage combinational signals
  logic          a_s, b_s, a_z, b_z, a_big;
  logic [Ne-1:0] x_e, y_e, diff;
  logic [Nm-1:0] x_m, y_m;
  logic [SW-1:0] sig_y, lost_mask, al_sx, al_sy;
  logic          al_sgn, al_sub, al_byp;
  logic [FW-1:0] al_byp_res;

  // NORM-stage combinational signals
  logic [CW-1:0]        lz, sh;
  logic [SW-1:0]        nm_sig;
  logic signed [EW-1:0] nm_exp;

  // ROUND-stage combinational signals
  logic                 rd_up, rd_c, rd_ovf, rd_unf;
  logic [Nm-1:0]        rd_man;
  logic signed [EW-1:0] rd_exp;
  logic [FW-1:0]        rd_res;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign ovf_o       = ovf_q;
  assign unf_o       = unf_q;

  // Order operands by magnitude and right-align the smaller one with sticky.
  always_comb begin
    a_s   = a_q[FW-1];
    b_s   = b_q[FW-1] ^ op_q;
    a_z   = (a_q[FW-2:Nm] == '0);
    b_z   = (b_q[FW-2:Nm] == '0);
    a_big = (a_q[FW-2:0] >= b_q[FW-2:0]);
    x_e   = a_big ? a_q[FW-2:Nm]  : b_q[FW-2:Nm];
    y_e   = a_big ? b_q[FW-2:Nm]  : a_q[FW-2:Nm];
    x_m   = a_big ? a_q[Nm-1:0]   : b_q[Nm-1:0];
    y_m   = a_big ? b_q[Nm-1:0]   : a_q[Nm-1:0];
    al_sgn = a_big ? a_s : b_s;
    al_sub = a_s ^ b_s;
    diff   = x_e - y_e;
    al_sx  = {1'b1, x_m, 3'b000};
    sig_y  = {1'b1, y_m, 3'b000};
    lost_mask = ~({SW{1'b1}} << diff);
    // Far enough away that only its presence matters for rounding.
    if (int'(diff) >= Nm + 3) al_sy = SW'(1);
    else                      al_sy = (sig_y >> diff) | SW'(|(sig_y & lost_mask));
    // A zero operand passes the other through untouched (no flags).
    al_byp = a_z | b_z;
    if (a_z & b_z) al_byp_res = '0;
    else if (a_z)  al_byp_res = {b_s, b_q[FW-2:0]};
    else           al_byp_res = a_q;
  end

  find_first_one #(.W(AW), .CW(CW)) u_lzc (
    .vec_i (sum_q),
    .lz_o  (lz)
  );

  // Renormalise the raw sum so the hidden one sits at bit SW-1.
  always_comb begin
    // lz counts the carry position, which is known clear on this path.
    sh = lz - CW'(1);
    if (sum_q[AW-1]) begin
      nm_sig = sum_q[AW-1:1] | SW'(sum_q[0]);
      nm_exp = exp_q + EONE;
    end else begin
      nm_sig = sum_q[SW-1:0] << sh;
      nm_exp = exp_q - EW'(sh);
    end
  end

  // Round to nearest even, then saturate or flush out-of-range exponents.
  always_comb begin
    rd_up            = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    {rd_c, rd_man}   = {1'b0, norm_q[SW-2:3]} + (Nm + 1)'(rd_up);
    rd_exp           = rd_c ? exp_q + EONE : exp_q;
    rd_res           = '0;
    rd_ovf           = 1'b0;
    rd_unf           = 1'b0;
    if (byp_q) begin
      rd_res = byp_res_q;
    end else if (!norm_q[SW-1]) begin
      // Exact cancellation: hidden bit never reached, result is +0.
      rd_res = '0;
    end else if (rd_exp > EMAX) begin
      rd_res = {sgn_q, EMAX[Ne-1:0], {Nm{1'b1}}};
      rd_ovf = 1'b1;
    end else if (rd_exp < EONE) begin
      rd_res = {sgn_q, {(FW-1){1'b0}}};
      rd_unf = 1'b1;
    end else begin
      rd_res = {sgn_q, rd_exp[Ne-1:0], rd_man};
    end
  end

  // Control FSM plus per-state datapath register loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= float_pack::IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      case (state_q)
        float_pack::IDLE: begin
          if (in_valid_i) begin
            a_q        <= a_i;
            b_q        <= b_i;
            op_q       <= op_i;
            in_ready_q <= 1'b0;
            state_q    <= float_pack::ALIGN;
          end
        end
        float_pack::ALIGN: begin
          sgn_q     <= al_sgn;
          sub_q     <= al_sub;
          exp_q     <= $signed({2'b00, x_e});
          sx_q      <= al_sx;
          sy_q      <= al_sy;
          byp_q     <= al_byp;
          byp_res_q <= al_byp_res;
          state_q   <= float_pack::ADD;
        end
        float_pack::ADD: begin
          sum_q   <= sub_q ? ({1'b0, sx_q} - {1'b0, sy_q})
                           : ({1'b0, sx_q} + {1'b0, sy_q});
          state_q <= float_pack::NORM;
        end
        float_pack::NORM: begin
          norm_q  <= nm_sig;
          exp_q   <= nm_exp;
          state_q <= float_pack::ROUND;
        end
        float_pack::ROUND: begin
          result_q    <= rd_res;
          ovf_q       <= rd_ovf;
          unf_q       <= rd_unf;
          out_valid_q <= 1'b1;
          state_q     <= float_pack::DONE;
        end
        float_pack::DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= float_pack::IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= float_pack::IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_addsub_seq.sv
// Scoreboard bench for float_addsub_seq (Ne=8, Nm=23): directed vectors,
// backpressure, reset mid-operation, and randomized operands checked
// against an exact wide-integer reference model.
module tb_float_addsub_seq;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, op = 1'b0;
  logic        out_valid, out_ready = 1'b1, ovf, unf;
  logic [31:0] a = '0, b = '0, res;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0, last_acc = 0, rdy_mode = 0;
  bit   prev_valid = 1'b0;

  always #5 clk = ~clk;

  float_addsub_seq #(.Ne(8), .Nm(23)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .op_i        (op),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (res),
    .ovf_o       (ovf),
    .unf_o       (unf)
  );

  always @(posedge clk) cyc++;

  // Consumer: always ready, random, or stalled.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Exact reference: integer sum scaled to the larger exponent, then RNE.
  function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi, input logic opi);
    exp_t e;
    float_pack::float_t fa, fb, f1, f2;
    int d, dd, p, sh, ex;
    logic [127:0] v1, v2, m, rem, half, q;
    logic signed [127:0] s;
    fa = ai; fb = bi; fb.sign = fb.sign ^ opi;
    e.res = '0; e.ovf = 1'b0; e.unf = 1'b0; e.acc = 0;
    if (fa.exp == 0 && fb.exp == 0) return e;
    if (fa.exp == 0) begin e.res = fb; return e; end
    if (fb.exp == 0) begin e.res = fa; return e; end
    if (fa.exp >= fb.exp) begin f1 = fa; f2 = fb; end
    else                  begin f1 = fb; f2 = fa; end
    d  = int'(f1.exp) - int'(f2.exp);
    dd = (d > 40) ? 40 : d;
    v1 = {104'd0, 1'b1, f1.man} << dd;
    // Beyond 40 bits the small operand only breaks ties, like a single unit.
    v2 = (d > 40) ? 128'd1 : {104'd0, 1'b1, f2.man};
    s  = (f1.sign ? -$signed(v1) : $signed(v1)) + (f2.sign ? -$signed(v2) : $signed(v2));
    if (s == 0) return e;
    e.res[31] = (s < 0);
    m = (s < 0) ? -s : s;
    p = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    ex = int'(f1.exp) - dd;
    if (p > 23) begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
      if (q == (128'd1 << 24)) begin q = q >> 1; ex = ex + 1; end
      ex = ex + sh;
    end else begin
      q  = m << (23 - p);
      ex = ex - (23 - p);
    end
    if (ex > 254) begin
      e.res[30:0] = {8'hFE, 23'h7FFFFF};
      e.ovf = 1'b1;
    end else if (ex < 1) begin
      e.res[30:0] = '0;
      e.unf = 1'b1;
    end else begin
      e.res[30:0] = {ex[7:0], q[22:0]};
    end
    return e;
  endfunction

  // Present one operation; push its expectation when it is accepted.
  task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input logic opi,
                       input logic [31:0] er, input logic eo, input logic eu, input bit push);
    int   w = 0;
    exp_t e;
    @(negedge clk);
    a = ai; b = bi; op = opi; in_valid = 1'b1;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready %b after %0d cycles, required 1", in_ready, w);
      in_valid = 1'b0;
    end else begin
      last_acc = cyc;
      if (push) begin
        e.res = er; e.ovf = eo; e.unf = eu; e.acc = cyc;
        sb.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || out_valid) && w < 1000) begin @(negedge clk); w++; end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: latency on the rising valid, data/flags every DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %h, required no output", res);
        end else begin
          if (!prev_valid) check("latency", 64'(cyc - sb[0].acc), 64'd5);
          check("result_flags", 64'({res, ovf, unf}), 64'({sb[0].res, sb[0].ovf, sb[0].unf}));
          check("in_ready_in_done", 64'(in_ready), 64'd0);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ai, bi;
    logic        opi;
    logic [7:0]  ea, eb;
    int          t, k, w;
    bit          saw;
    exp_t        e;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(res),       64'd0);
    check("rst_flags",     64'({ovf, unf}), 64'd0);
    rst = 1'b0;

    // Directed vectors
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1);
    issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 1);
    issue(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1);
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1);
    issue(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b0, 1);
    issue(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b1, 1);
    issue(32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1);
    issue(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);
    issue(32'h7F800000, 32'h00000000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1);
    issue(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);
    issue(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b0, 1);
    issue(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0, 1);
    drain();

    // Backpressure: hold the result for 10 cycles in DONE
    rdy_mode = 2;
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1);
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    repeat (10) @(negedge clk);
    check("stall_valid_held", 64'(out_valid), 64'd1);
    check("stall_not_ready",  64'(in_ready),  64'd0);
    rdy_mode = 0;
    drain();

    // Reset while the operation sits in NORM: nothing may come out
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    w = 0;
    while (cyc < last_acc + 3 && w < 20) begin @(negedge clk); w++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result",    64'({res, ovf, unf}), 64'd0);
    saw = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) saw = 1'b1; end
    check("midrst_no_output", 64'(saw), 64'd0);

    // Randomized operands, random consumer readiness
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 19));
      if (k == 0)      ea = 8'd0;
      else if (k == 1) ea = 8'd255;
      else if (k == 2) ea = 8'($urandom_range(1, 4));
      else             ea = 8'($urandom_range(1, 254));
      k = int'($urandom_range(0, 3));
      if (k <= 1)      t = int'(ea) + int'($urandom_range(0, 6)) - 3;
      else if (k == 2) t = int'($urandom_range(0, 255));
      else             t = int'(ea) - int'($urandom_range(20, 30));
      t  = (t < 0) ? 0 : ((t > 255) ? 255 : t);
      eb = t[7:0];
      ai = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
      bi = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
      if ($urandom_range(0, 7) == 0) bi[22:0] = ai[22:0];
      opi = 1'($urandom_range(0, 1));
      e = model(ai, bi, opi);
      issue(ai, bi, opi, e.res, e.ovf, e.unf, 1);
    end
    rdy_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
